// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: loader FSM states, opcode constants and an 8-bit
// wrap-around add helper.
package sap1_pkg;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    ESPERA    = 2'd1,
    ESCRITA   = 2'd2,
    CONCLUIDO = 2'd3
  } estado_t;

  localparam logic [3:0] LDA = 4'h0;
  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] SUB = 4'h2;
  localparam logic [3:0] OUT = 4'hE;
  localparam logic [3:0] HLT = 4'hF;

  function automatic logic [7:0] soma8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/carregador_ram.sv
// Loads PALAVRAS bytes into the external 16x8 SAP-1 program memory, holding the CPU while open.
// Write strobe one cycle after each accepted byte; dado_pronto drops during the write (1 byte / 2 cycles).
module carregador_ram
  import sap1_pkg::*;
#(
  parameter int PALAVRAS = 16
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       iniciar,
  input  logic       abortar,
  input  logic [7:0] dado,
  input  logic       dado_valido,
  output logic       dado_pronto,
  output logic       mem_we,
  output logic [3:0] mem_endereco,
  output logic [7:0] mem_dado,
  output logic       carregando,
  output logic       concluido,
  output logic [4:0] contagem,
  output logic [7:0] soma,
  output logic       cpu_clr_n
);

  localparam logic [4:0] ULTIMA = 5'(PALAVRAS);

  estado_t    estado_q;
  logic       pronto_q;
  logic       we_q;
  logic       carregando_q;
  logic       concluido_q;
  logic [3:0] endereco_q;
  logic [7:0] dado_q;
  logic [4:0] contagem_q;
  logic [7:0] soma_q;
  logic [4:0] contagem_d;
  logic [7:0] soma_d;

  always_comb begin
    contagem_d = contagem_q + 5'd1;
    soma_d     = soma8(soma_q, dado_q);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      estado_q     <= OCIOSO;
      pronto_q     <= 1'b0;
      we_q         <= 1'b0;
      carregando_q <= 1'b0;
      concluido_q  <= 1'b0;
      endereco_q   <= 4'd0;
      dado_q       <= 8'd0;
      contagem_q   <= 5'd0;
      soma_q       <= 8'd0;
    end else begin
      case (estado_q)
        OCIOSO, CONCLUIDO: begin
          if (iniciar && !abortar) begin
            estado_q     <= ESPERA;
            pronto_q     <= 1'b1;
            carregando_q <= 1'b1;
            concluido_q  <= 1'b0;
            contagem_q   <= 5'd0;
            soma_q       <= 8'd0;
          end
        end
        // Abort wins over a simultaneous handshake: the offered byte is dropped.
        ESPERA: begin
          if (abortar) begin
            estado_q     <= OCIOSO;
            pronto_q     <= 1'b0;
            carregando_q <= 1'b0;
          end else if (dado_valido && pronto_q) begin
            estado_q   <= ESCRITA;
            pronto_q   <= 1'b0;
            we_q       <= 1'b1;
            endereco_q <= contagem_q[3:0];
            dado_q     <= dado;
          end
        end
        ESCRITA: begin
          we_q       <= 1'b0;
          contagem_q <= contagem_d;
          soma_q     <= soma_d;
          if (contagem_d == ULTIMA) begin
            estado_q     <= CONCLUIDO;
            concluido_q  <= 1'b1;
            carregando_q <= 1'b0;
          end else if (abortar) begin
            estado_q     <= OCIOSO;
            carregando_q <= 1'b0;
          end else begin
            estado_q <= ESPERA;
            pronto_q <= 1'b1;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign dado_pronto  = pronto_q;
  assign mem_we       = we_q;
  assign mem_endereco = endereco_q;
  assign mem_dado     = dado_q;
  assign carregando   = carregando_q;
  assign concluido    = concluido_q;
  assign contagem     = contagem_q;
  assign soma         = soma_q;
  assign cpu_clr_n    = ~carregando_q;

endmodule

// File: tb/tb_carregador_ram.sv
// Scoreboard bench for carregador_ram: drivers queue expected writes, monitors check each mem_we pulse.
module tb_carregador_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr_n;
  logic       iniciar, abortar, dado_valido;
  logic [7:0] dado;
  logic       dado_pronto, mem_we, carregando, concluido, cpu_clr_n;
  logic [3:0] mem_endereco;
  logic [7:0] mem_dado, soma;
  logic [4:0] contagem;

  logic       i4, a4, v4;
  logic [7:0] d4;
  logic       pronto4, we4, carr4, concl4, cpu4;
  logic [3:0] end4;
  logic [7:0] mdado4, soma4;
  logic [4:0] cont4;

  carregador_ram dut (
    .clk(clk), .clr_n(clr_n), .iniciar(iniciar), .abortar(abortar),
    .dado(dado), .dado_valido(dado_valido), .dado_pronto(dado_pronto),
    .mem_we(mem_we), .mem_endereco(mem_endereco), .mem_dado(mem_dado),
    .carregando(carregando), .concluido(concluido), .contagem(contagem),
    .soma(soma), .cpu_clr_n(cpu_clr_n)
  );

  carregador_ram #(.PALAVRAS(4)) dut4 (
    .clk(clk), .clr_n(clr_n), .iniciar(i4), .abortar(a4),
    .dado(d4), .dado_valido(v4), .dado_pronto(pronto4),
    .mem_we(we4), .mem_endereco(end4), .mem_dado(mdado4),
    .carregando(carr4), .concluido(concl4), .contagem(cont4),
    .soma(soma4), .cpu_clr_n(cpu4)
  );

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
    int         c;
  } wr_t;

  wr_t q16[$];
  wr_t q4[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;

  logic [7:0] tab1 [16] = '{8'h0A, 8'h1B, 8'h2C, 8'h3D, 8'hE0, 8'hF0, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h01, 8'h04, 8'h05, 8'h06, 8'h00, 8'h00};
  logic [7:0] tab2 [5]  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nome, got, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (mem_we === 1'b1) begin
      if (q16.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL we16_unexpected: write addr %0d data 0x%0h, expected no write", mem_endereco, mem_dado);
      end else begin
        e = q16.pop_front();
        chk("we16_addr", 32'(mem_endereco), 32'(e.a));
        chk("we16_data", 32'(mem_dado), 32'(e.d));
        chk("we16_cycle", cyc, e.c);
      end
    end
  end

  always @(negedge clk) begin
    wr_t e;
    if (we4 === 1'b1) begin
      if (q4.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL we4_unexpected: write addr %0d data 0x%0h, expected no write", end4, mdado4);
      end else begin
        e = q4.pop_front();
        chk("we4_addr", 32'(end4), 32'(e.a));
        chk("we4_data", 32'(mdado4), 32'(e.d));
        chk("we4_cycle", cyc, e.c);
      end
    end
  end

  task automatic ciclos(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulso(input bit u4, input bit ini, input bit abt);
    if (u4) begin i4 = ini; a4 = abt; end
    else begin iniciar = ini; abortar = abt; end
    ciclos(1);
    if (u4) begin i4 = 1'b0; a4 = 1'b0; end
    else begin iniciar = 1'b0; abortar = 1'b0; end
  endtask

  // Offers one byte; once dado_pronto is seen the following edge is the transfer,
  // so the strobe is expected in the cycle that edge opens.
  task automatic send(input bit u4, input logic [7:0] b, input logic [3:0] a,
                      input int gap, input bit esperado);
    bit  ok;
    wr_t e;
    ok = 1'b0;
    ciclos(gap);
    if (u4) begin d4 = b; v4 = 1'b1; end
    else begin dado = b; dado_valido = 1'b1; end
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if ((u4 ? pronto4 : dado_pronto) === 1'b1) begin
        ok  = 1'b1;
        e.a = a;
        e.d = b;
        e.c = cyc + 1;
        if (esperado) begin
          if (u4) q4.push_back(e);
          else q16.push_back(e);
        end
        ciclos(1);
        if (u4) v4 = 1'b0;
        else dado_valido = 1'b0;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: byte 0x%0h never accepted, expected dado_pronto within 50 cycles", b);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_dado_pronto"}, 32'(dado_pronto), 0);
    chk({tag, "_carregando"}, 32'(carregando), 0);
    chk({tag, "_concluido"}, 32'(concluido), 0);
    chk({tag, "_contagem"}, 32'(contagem), 0);
    chk({tag, "_soma"}, 32'(soma), 0);
    chk({tag, "_mem_endereco"}, 32'(mem_endereco), 0);
    chk({tag, "_mem_dado"}, 32'(mem_dado), 0);
    chk({tag, "_cpu_clr_n"}, 32'(cpu_clr_n), 1);
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_n = 1'b0;
    iniciar = 1'b0; abortar = 1'b0; dado_valido = 1'b0; dado = 8'h00;
    i4 = 1'b0; a4 = 1'b0; v4 = 1'b0; d4 = 8'h00;
    #3;
    chk_reset("rst");
    chk("rst4_carregando", 32'(carr4), 0);
    #5 clr_n = 1'b1;
    @(posedge clk);
    #1;
    ciclos(1);
    chk("idle_after_rst", 32'(carregando), 0);

    // Full session, back-to-back bytes.
    pulso(0, 1, 0);
    chk("s1_carregando", 32'(carregando), 1);
    chk("s1_cpu_hold", 32'(cpu_clr_n), 0);
    chk("s1_pronto", 32'(dado_pronto), 1);
    for (int i = 0; i < 16; i++) send(0, tab1[i], 4'(i), 0, 1);
    ciclos(2);
    chk("s1_concluido", 32'(concluido), 1);
    chk("s1_contagem", 32'(contagem), 16);
    chk("s1_soma", 32'(soma), 32'h6E);
    chk("s1_carregando_end", 32'(carregando), 0);
    chk("s1_cpu_release", 32'(cpu_clr_n), 1);

    // Sparse valid, then abort while waiting (iniciar alongside must not matter).
    pulso(0, 1, 0);
    chk("s2_contagem_clr", 32'(contagem), 0);
    chk("s2_soma_clr", 32'(soma), 0);
    chk("s2_concluido_clr", 32'(concluido), 0);
    for (int i = 0; i < 5; i++) send(0, tab2[i], 4'(i), 2, 1);
    ciclos(2);
    chk("s2_pronto_wait", 32'(dado_pronto), 1);
    pulso(0, 1, 1);
    chk("ab_carregando", 32'(carregando), 0);
    chk("ab_cpu_clr_n", 32'(cpu_clr_n), 1);
    chk("ab_concluido", 32'(concluido), 0);
    chk("ab_contagem", 32'(contagem), 5);
    chk("ab_soma", 32'(soma), 32'hFF);
    chk("ab_pronto", 32'(dado_pronto), 0);
    pulso(0, 1, 1);
    chk("ab_prio_idle", 32'(carregando), 0);
    chk("ab_prio_contagem", 32'(contagem), 5);

    // Restart from address 0; abort during the third write.
    pulso(0, 1, 0);
    chk("s3_contagem_clr", 32'(contagem), 0);
    send(0, 8'h80, 4'd0, 0, 1);
    send(0, 8'h81, 4'd1, 0, 1);
    send(0, 8'h90, 4'd2, 0, 1);
    chk("s3_we_pending", 32'(mem_we), 1);
    abortar = 1'b1;
    ciclos(1);
    abortar = 1'b0;
    chk("s3_carregando", 32'(carregando), 0);
    chk("s3_contagem", 32'(contagem), 3);
    chk("s3_soma", 32'(soma), 32'h91);
    chk("s3_concluido", 32'(concluido), 0);
    chk("s3_pronto", 32'(dado_pronto), 0);
    ciclos(2);

    // Reset asserted between edges while the strobe is high.
    pulso(0, 1, 0);
    send(0, 8'h5A, 4'd0, 0, 0);
    chk("mid_we_before", 32'(mem_we), 1);
    #2 clr_n = 1'b0;
    #1 chk_reset("mid");
    #3 clr_n = 1'b1;
    @(posedge clk);
    #1;
    ciclos(2);
    chk("mid_idle_after", 32'(carregando), 0);

    // PALAVRAS=4 instance: sum wraps, extra valid after completion is not taken.
    pulso(1, 1, 0);
    for (int i = 0; i < 4; i++) send(1, 8'hFF, 4'(i), 0, 1);
    d4 = 8'h77;
    v4 = 1'b1;
    ciclos(1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("p4_pronto_done", 32'(pronto4), 0);
    end
    ciclos(1);
    v4 = 1'b0;
    chk("p4_concluido", 32'(concl4), 1);
    chk("p4_contagem", 32'(cont4), 4);
    chk("p4_soma", 32'(soma4), 32'hFC);
    chk("p4_carregando", 32'(carr4), 0);
    chk("p4_cpu_clr_n", 32'(cpu4), 1);

    ciclos(3);
    chk("q16_drained", q16.size(), 0);
    chk("q4_drained", q4.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
